// File: rtl/mirfak_icache_if.sv
// Wishbone classic single-beat read bus: master drives address/strobe, slave returns data with ack or err.
// Used for both the fetch side (cache is slave) and the refill side (cache is master).
interface mirfak_icache_if;
  logic [31:0] addr;
  logic        cyc;
  logic        stb;
  logic [31:0] dat;
  logic        ack;
  logic        err;

  modport master (output addr, output cyc, output stb, input dat, input ack, input err);
  modport slave  (input addr, input cyc, input stb, output dat, output ack, output err);
endinterface

// File: rtl/mirfak_icache.sv
// Direct-mapped read-only I-cache: hit acks one cycle after sampling, miss refills a whole line beat by beat.
// Fetch side stalls via withheld ack; refill beats wait on ack_i/err_i; flush_i invalidates every line.
module mirfak_icache #(
  parameter int NLINES     = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  mirfak_icache_if.slave  iwbs,
  mirfak_icache_if.master iwbm
);
  localparam int OFS  = $clog2(LINE_WORDS);
  localparam int IDX  = $clog2(NLINES);
  localparam int TAGW = 30 - OFS - IDX;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_FLUSH} state_t;
  state_t r_state, w_state_nxt;

  logic [NLINES-1:0]  r_valid;
  logic [TAGW-1:0]    r_tag  [NLINES];
  logic [31:0]        r_data [NLINES*LINE_WORDS];

  logic [29-OFS:0]    r_line;
  logic [OFS-1:0]     r_req_ofs;
  logic [OFS-1:0]     r_beat;
  logic [31:0]        r_cap;
  logic               r_pend;
  logic               r_ack, r_err;
  logic [31:0]        r_dat;
  logic               r_cyc, r_stb;
  logic [31:0]        r_addr;

  logic [OFS-1:0]     w_ofs;
  logic [IDX-1:0]     w_idx;
  logic [TAGW-1:0]    w_tag;
  logic [IDX-1:0]     w_ref_idx;
  logic [TAGW-1:0]    w_ref_tag;
  logic               w_req, w_hit, w_same, w_flush_any;
  logic               w_beat_ack, w_beat_err, w_last;
  logic               w_ack_d, w_err_d;
  logic [31:0]        w_dat_d;
  logic               w_unused;

  assign w_ofs       = iwbs.addr[OFS+1:2];
  assign w_idx       = iwbs.addr[OFS+IDX+1:OFS+2];
  assign w_tag       = iwbs.addr[31:OFS+IDX+2];
  assign w_ref_idx   = r_line[IDX-1:0];
  assign w_ref_tag   = r_line[29-OFS:IDX];
  assign w_unused    = &{1'b0, iwbs.addr[1:0]};

  // An ack/err in flight masks the request so each fetch is answered once.
  assign w_req       = iwbs.cyc && iwbs.stb && !r_ack && !r_err;
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_same      = iwbs.cyc && iwbs.stb && (iwbs.addr[31:2] == {r_line, r_req_ofs});
  assign w_flush_any = r_pend || flush_i;
  assign w_beat_err  = (r_state == S_REFILL) && r_stb && iwbm.err;
  assign w_beat_ack  = (r_state == S_REFILL) && r_stb && iwbm.ack && !iwbm.err;
  assign w_last      = w_beat_ack && (&r_beat);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (flush_i) w_state_nxt = S_FLUSH;
                else if (w_req && !w_hit) w_state_nxt = S_REFILL;
      S_REFILL: if (w_beat_err || w_last) w_state_nxt = w_flush_any ? S_FLUSH : S_IDLE;
      S_FLUSH:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ack_d = 1'b0;
    w_err_d = 1'b0;
    w_dat_d = r_dat;
    case (r_state)
      S_IDLE: if (!flush_i && w_req && w_hit) begin
        w_ack_d = 1'b1;
        w_dat_d = r_data[{w_idx, w_ofs}];
      end
      S_REFILL: if (w_beat_err) begin
        w_err_d = w_same;
      end else if (w_last) begin
        w_ack_d = w_same;
        w_dat_d = (r_beat == r_req_ofs) ? iwbm.dat : r_cap;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid   <= '0;
      r_pend    <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_dat     <= '0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_addr    <= '0;
      r_line    <= '0;
      r_req_ofs <= '0;
      r_beat    <= '0;
      r_cap     <= '0;
    end else begin
      r_ack <= w_ack_d;
      r_err <= w_err_d;
      r_dat <= w_dat_d;
      case (r_state)
        S_IDLE: if (!flush_i && w_req && !w_hit) begin
          r_line         <= iwbs.addr[31:OFS+2];
          r_req_ofs      <= w_ofs;
          r_beat         <= '0;
          r_addr         <= {iwbs.addr[31:OFS+2], {(OFS+2){1'b0}}};
          r_cyc          <= 1'b1;
          r_stb          <= 1'b1;
          r_pend         <= 1'b0;
          // Line is overwritten in place, so it must not hit until refilled.
          r_valid[w_idx] <= 1'b0;
        end
        S_REFILL: begin
          if (flush_i) r_pend <= 1'b1;
          if (w_beat_err) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
          end else if (w_beat_ack) begin
            if (r_beat == r_req_ofs) r_cap <= iwbm.dat;
            if (w_last) begin
              r_cyc              <= 1'b0;
              r_stb              <= 1'b0;
              r_valid[w_ref_idx] <= !w_flush_any;
            end else begin
              r_beat <= r_beat + 1'b1;
              r_addr <= r_addr + 32'd4;
            end
          end
        end
        S_FLUSH: begin
          r_valid <= '0;
          r_pend  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_beat_ack) r_data[{w_ref_idx, r_beat}] <= iwbm.dat;
    if (w_last)     r_tag[w_ref_idx] <= w_ref_tag;
  end

  assign iwbs.ack  = r_ack;
  assign iwbs.err  = r_err;
  assign iwbs.dat  = r_dat;
  assign iwbm.cyc  = r_cyc;
  assign iwbm.stb  = r_stb;
  assign iwbm.addr = r_addr;
endmodule
